// File: rtl/pkt_slot_scheduler.sv
// Packet-slot pool allocator: zero-latency grant of the lowest free, enabled slot and strobe-based release.
// Optional statistics counters are built when SLOT_STATS_EN is defined; otherwise the stat ports read 0.
module pkt_slot_scheduler #(
  parameter int SLOT_COUNT = 4,
  parameter int SLOT_WIDTH = (SLOT_COUNT > 1) ? $clog2(SLOT_COUNT) : 1,
  parameter int ADDR_WIDTH = 16,
  parameter int LEAD_ZERO  = 8,
  parameter int DEST_WIDTH = ADDR_WIDTH - LEAD_ZERO,
  parameter logic [DEST_WIDTH-1:0] SLOT_BASE   = DEST_WIDTH'(8'h10),
  parameter logic [DEST_WIDTH-1:0] SLOT_STRIDE = DEST_WIDTH'(8'h10),
  parameter int CNT_WIDTH  = $clog2(SLOT_COUNT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SLOT_COUNT-1:0] i_slot_en_mask,
  input  logic                  i_alloc_valid,
  output logic                  o_alloc_ready,
  output logic [SLOT_WIDTH-1:0] o_alloc_slot,
  output logic [DEST_WIDTH-1:0] o_alloc_dest,
  input  logic                  i_release_valid,
  input  logic [SLOT_WIDTH-1:0] i_release_slot,
  output logic [CNT_WIDTH-1:0]  o_free_count,
  output logic                  o_busy_all,
  output logic                  o_err_bad_release,
  input  logic                  i_clear_err,
  output logic [31:0]           o_stat_allocs,
  output logic [31:0]           o_stat_releases,
  output logic [CNT_WIDTH-1:0]  o_stat_peak_busy
);

  logic [SLOT_COUNT-1:0] r_free;
  logic [CNT_WIDTH-1:0]  r_count;
  logic                  r_err;

  logic [SLOT_COUNT-1:0] w_cand;
  logic [SLOT_COUNT-1:0] w_grant_oh;
  logic [SLOT_COUNT-1:0] w_rel_oh;
  logic [SLOT_WIDTH-1:0] w_slot;
  logic [DEST_WIDTH-1:0] w_dest_calc;
  logic [CNT_WIDTH-1:0]  w_count_next;
  logic                  w_any;
  logic                  w_grant;
  logic                  w_rel_hit;
  logic                  w_rel_legal;
  logic                  w_rel_bad;

  assign w_cand = r_free & i_slot_en_mask;
  assign w_any  = |w_cand;

  // Descending scan so the lowest set candidate is the last one written.
  always_comb begin
    w_slot = '0;
    for (int i = SLOT_COUNT - 1; i >= 0; i--) begin
      if (w_cand[i]) w_slot = SLOT_WIDTH'(i);
    end
  end

  assign o_alloc_ready = w_any & ~rst;
  assign w_grant       = i_alloc_valid & o_alloc_ready;
  assign o_busy_all    = ~w_any;
  assign o_alloc_slot  = w_slot;
  assign w_dest_calc   = SLOT_BASE + DEST_WIDTH'(w_slot) * SLOT_STRIDE;
  assign o_alloc_dest  = w_any ? w_dest_calc : '0;

  // Out-of-range release indices decode to no bit at all, so they can never look busy.
  always_comb begin
    w_grant_oh = '0;
    w_rel_oh   = '0;
    for (int i = 0; i < SLOT_COUNT; i++) begin
      w_grant_oh[i] = w_grant && (w_slot == SLOT_WIDTH'(i));
      w_rel_oh[i]   = (i_release_slot == SLOT_WIDTH'(i));
    end
  end

  assign w_rel_hit   = |(w_rel_oh & ~r_free);
  assign w_rel_legal = i_release_valid & w_rel_hit;
  assign w_rel_bad   = i_release_valid & ~w_rel_hit;

  always_comb begin
    w_count_next = r_count;
    if (w_rel_legal && !w_grant)
      w_count_next = r_count + CNT_WIDTH'(1);
    else if (!w_rel_legal && w_grant)
      w_count_next = r_count - CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_free  <= '1;
      r_count <= CNT_WIDTH'(SLOT_COUNT);
      r_err   <= 1'b0;
    end else begin
      r_free  <= (r_free | (w_rel_legal ? w_rel_oh : '0)) & ~w_grant_oh;
      r_count <= w_count_next;
      if (w_rel_bad)
        r_err <= 1'b1;
      else if (i_clear_err)
        r_err <= 1'b0;
    end
  end

  assign o_free_count      = r_count;
  assign o_err_bad_release = r_err;

`ifdef SLOT_STATS_EN
  logic [31:0]          r_stat_allocs;
  logic [31:0]          r_stat_releases;
  logic [CNT_WIDTH-1:0] r_stat_peak;
  logic [CNT_WIDTH-1:0] w_busy_next;

  // Peak tracks the busy count as it will be after this edge.
  assign w_busy_next = CNT_WIDTH'(SLOT_COUNT) - w_count_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_allocs   <= '0;
      r_stat_releases <= '0;
      r_stat_peak     <= '0;
    end else begin
      if (w_grant)     r_stat_allocs   <= r_stat_allocs + 32'd1;
      if (w_rel_legal) r_stat_releases <= r_stat_releases + 32'd1;
      if (w_busy_next > r_stat_peak) r_stat_peak <= w_busy_next;
    end
  end

  assign o_stat_allocs    = r_stat_allocs;
  assign o_stat_releases  = r_stat_releases;
  assign o_stat_peak_busy = r_stat_peak;
`else
  assign o_stat_allocs    = '0;
  assign o_stat_releases  = '0;
  assign o_stat_peak_busy = '0;
`endif

endmodule

// File: tb/tb_pkt_slot_scheduler.sv
// Bench for pkt_slot_scheduler: vector table with expected-output scoreboard plus hand sequences
// for statistics and a 3-slot (non power of two) build.
module tb_pkt_slot_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 4-slot instance
  logic [3:0]  mask;
  logic        av, rv, clr;
  logic [1:0]  rs;
  logic        ready, busy, err;
  logic [1:0]  slot;
  logic [7:0]  dest;
  logic [2:0]  cnt, peak;
  logic [31:0] s_alloc, s_rel;

  pkt_slot_scheduler dut (
    .clk(clk), .rst(rst), .i_slot_en_mask(mask), .i_alloc_valid(av), .o_alloc_ready(ready),
    .o_alloc_slot(slot), .o_alloc_dest(dest), .i_release_valid(rv), .i_release_slot(rs),
    .o_free_count(cnt), .o_busy_all(busy), .o_err_bad_release(err), .i_clear_err(clr),
    .o_stat_allocs(s_alloc), .o_stat_releases(s_rel), .o_stat_peak_busy(peak)
  );

  // 3-slot instance
  logic [2:0]  d3_mask;
  logic        d3_av, d3_rv, d3_clr;
  logic [1:0]  d3_rs;
  logic        d3_ready, d3_busy, d3_err;
  logic [1:0]  d3_slot, d3_cnt, d3_peak;
  logic [7:0]  d3_dest;
  logic [31:0] d3_s_alloc, d3_s_rel;

  pkt_slot_scheduler #(.SLOT_COUNT(3)) dut3 (
    .clk(clk), .rst(rst), .i_slot_en_mask(d3_mask), .i_alloc_valid(d3_av), .o_alloc_ready(d3_ready),
    .o_alloc_slot(d3_slot), .o_alloc_dest(d3_dest), .i_release_valid(d3_rv), .i_release_slot(d3_rs),
    .o_free_count(d3_cnt), .o_busy_all(d3_busy), .o_err_bad_release(d3_err), .i_clear_err(d3_clr),
    .o_stat_allocs(d3_s_alloc), .o_stat_releases(d3_s_rel), .o_stat_peak_busy(d3_peak)
  );

  typedef struct {
    logic       rst, av, rv;
    logic [1:0] rs;
    logic [3:0] mask;
    logic       clr;
    logic       e_ready;
    logic [1:0] e_slot;
    logic [7:0] e_dest;
    logic [2:0] e_cnt;
    logic       e_busy, e_err;
  } vec_t;

  typedef struct {
    int         idx;
    logic       ready;
    logic [1:0] slot;
    logic [7:0] dest;
    logic [2:0] cnt;
    logic       busy, err;
  } exp_t;

  localparam int NVEC = 27;
  vec_t vecs[NVEC];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(int r, int a, int v, int s, int m, int c,
                              int er, int es, int ed, int ec, int eb, int ee);
    vec_t t;
    t.rst = r[0]; t.av = a[0]; t.rv = v[0]; t.rs = s[1:0]; t.mask = m[3:0]; t.clr = c[0];
    t.e_ready = er[0]; t.e_slot = es[1:0]; t.e_dest = ed[7:0]; t.e_cnt = ec[2:0];
    t.e_busy = eb[0]; t.e_err = ee[0];
    return t;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(vec_t v, int idx);
    exp_t e;
    @(negedge clk);
    rst = v.rst; av = v.av; rv = v.rv; rs = v.rs; mask = v.mask; clr = v.clr;
    sb.push_back('{idx, v.e_ready, v.e_slot, v.e_dest, v.e_cnt, v.e_busy, v.e_err});
    #2;
    e = sb.pop_front();
    chk("ready", e.idx, 32'(ready), 32'(e.ready));
    chk("slot",  e.idx, 32'(slot),  32'(e.slot));
    chk("dest",  e.idx, 32'(dest),  32'(e.dest));
    chk("count", e.idx, 32'(cnt),   32'(e.cnt));
    chk("busy",  e.idx, 32'(busy),  32'(e.busy));
    chk("err",   e.idx, 32'(err),   32'(e.err));
  endtask

  task automatic cyc(logic a, logic v, logic [1:0] s);
    @(negedge clk);
    rst = 1'b0; av = a; rv = v; rs = s; mask = 4'hF; clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    // rst | av rv rs mask clr || ready slot dest cnt busy err
    vecs[0]  = mk(1, 1,0,0,'hF,0,  0,0,'h10,4,0,0);
    vecs[1]  = mk(0, 1,0,0,'hF,0,  1,0,'h10,4,0,0);
    vecs[2]  = mk(0, 1,0,0,'hF,0,  1,1,'h20,3,0,0);
    vecs[3]  = mk(0, 1,0,0,'hF,0,  1,2,'h30,2,0,0);
    vecs[4]  = mk(0, 1,0,0,'hF,0,  1,3,'h40,1,0,0);
    vecs[5]  = mk(0, 1,0,0,'hF,0,  0,0,'h00,0,1,0);
    vecs[6]  = mk(0, 0,1,2,'hF,0,  0,0,'h00,0,1,0);
    vecs[7]  = mk(0, 1,1,0,'hF,0,  1,2,'h30,1,0,0);
    vecs[8]  = mk(0, 0,0,0,'hF,0,  1,0,'h10,1,0,0);
    vecs[9]  = mk(0, 0,1,0,'hF,0,  1,0,'h10,1,0,0);
    vecs[10] = mk(0, 0,0,0,'hF,1,  1,0,'h10,1,0,1);
    vecs[11] = mk(0, 1,1,0,'hF,0,  1,0,'h10,1,0,0);
    vecs[12] = mk(0, 0,0,0,'hF,1,  0,0,'h00,0,1,1);
    vecs[13] = mk(0, 0,1,3,'hF,0,  0,0,'h00,0,1,0);
    vecs[14] = mk(0, 0,1,3,'hF,1,  1,3,'h40,1,0,0);
    vecs[15] = mk(0, 0,0,0,'hF,0,  1,3,'h40,1,0,1);
    vecs[16] = mk(1, 1,0,0,'hF,0,  0,3,'h40,1,0,1);
    vecs[17] = mk(0, 0,0,0,'hF,0,  1,0,'h10,4,0,0);
    vecs[18] = mk(0, 1,0,0,'hA,0,  1,1,'h20,4,0,0);
    vecs[19] = mk(0, 1,0,0,'hA,0,  1,3,'h40,3,0,0);
    vecs[20] = mk(0, 1,0,0,'hA,0,  0,0,'h00,2,1,0);
    vecs[21] = mk(0, 1,0,0,'hF,0,  1,0,'h10,2,0,0);
    vecs[22] = mk(0, 1,0,0,'hF,0,  1,2,'h30,1,0,0);
    vecs[23] = mk(0, 0,0,0,'hF,0,  0,0,'h00,0,1,0);
    vecs[24] = mk(0, 0,1,2,'h1,0,  0,0,'h00,0,1,0);
    vecs[25] = mk(0, 1,0,0,'h1,0,  0,0,'h00,1,1,0);
    vecs[26] = mk(0, 0,0,0,'hF,0,  1,2,'h30,1,0,0);

    rst = 1'b1; av = 1'b0; rv = 1'b0; rs = '0; mask = 4'hF; clr = 1'b0;
    d3_mask = 3'b111; d3_av = 1'b0; d3_rv = 1'b0; d3_rs = '0; d3_clr = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NVEC; i++) apply(vecs[i], i);

    // Statistics: 6 grants, 5 releases, at most 3 slots busy at once
    @(negedge clk); rst = 1'b1; av = 1'b0; rv = 1'b0; clr = 1'b0; mask = 4'hF;
    cyc(1, 0, 0); cyc(1, 0, 0); cyc(1, 0, 0);
    cyc(0, 1, 0); cyc(0, 1, 1);
    cyc(1, 0, 0); cyc(1, 0, 0);
    cyc(0, 1, 0); cyc(0, 1, 1); cyc(0, 1, 2);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    #2;
    chk("stats_count", 0, 32'(cnt), 32'd3);
`ifdef SLOT_STATS_EN
    chk("stat_allocs",   0, s_alloc,     32'd6);
    chk("stat_releases", 0, s_rel,       32'd5);
    chk("stat_peak",     0, 32'(peak),   32'd3);
`else
    chk("stat_allocs",   0, s_alloc,     32'd0);
    chk("stat_releases", 0, s_rel,       32'd0);
    chk("stat_peak",     0, 32'(peak),   32'd0);
`endif

    // 3-slot build: index 3 is out of range
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; d3_rv = 1'b1; d3_rs = 2'd3;
    #2;
    chk("d3_err_pre", 0, 32'(d3_err), 32'd0);
    @(negedge clk); d3_rv = 1'b0; d3_rs = 2'd0;
    #2;
    chk("d3_err_range", 0, 32'(d3_err), 32'd1);
    chk("d3_count",     0, 32'(d3_cnt), 32'd3);
    d3_clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); d3_clr = 1'b0; d3_av = 1'b1;
      #2;
      chk("d3_slot", i, 32'(d3_slot), 32'(i));
      chk("d3_dest", i, 32'(d3_dest), 32'(8'h10 + 8'(i) * 8'h10));
    end
    @(negedge clk);
    #2;
    chk("d3_ready_empty", 0, 32'(d3_ready), 32'd0);
    chk("d3_count_empty", 0, 32'(d3_cnt),   32'd0);
    chk("d3_err_cleared", 0, 32'(d3_err),   32'd0);
    d3_av = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
